// File: rtl/dispatch_ctrl.sv
// Dispatch resource controller: ROB, store-queue and issue-queue credit tracking for a dual-issue core.
// Optional stall-cause performance counters are compiled in when DISPATCH_PERF_CNT_EN is defined.
module dispatch_ctrl #(
    parameter int ROB_DEPTH      = 16,
    parameter int SQ_DEPTH       = 16,
    parameter int IQ_DEPTH       = 8,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ds_valid,
    input  logic                         inst1_valid,
    input  logic                         inst2_valid,
    input  logic                         inst1_is_store_op,
    input  logic                         inst2_is_store_op,
    input  logic [1:0]                   rob_commit_num,
    input  logic [1:0]                   rob_commit_store_num,
    input  logic                         sq_drain_num,
    input  logic [1:0]                   iq_release_num,
    input  logic                         flush,
    output logic                         ds_to_is_valid,
    output logic                         ds_to_rob_valid,
    output logic                         ds_allowin,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_head_o,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_tail_o,
    output logic [$clog2(SQ_DEPTH)-1:0]  store_head,
    output logic [$clog2(SQ_DEPTH)-1:0]  store_tail,
    output logic                         rob_full,
    output logic                         sq_full
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_rob_cnt,
    output logic [31:0]                  stall_sq_cnt,
    output logic [31:0]                  stall_iq_cnt,
    output logic [31:0]                  stall_rec_cnt
`endif
);

    localparam int AW  = $clog2(ROB_DEPTH);
    localparam int SW  = $clog2(SQ_DEPTH);
    localparam int RCW = AW + 1;
    localparam int SCW = SW + 1;
    localparam int IW  = $clog2(IQ_DEPTH) + 1;

    localparam logic [RCW-1:0] ROB_CAP     = RCW'(ROB_DEPTH);
    localparam logic [SCW-1:0] SQ_CAP      = SCW'(SQ_DEPTH);
    localparam logic [IW-1:0]  IQ_CAP      = IW'(IQ_DEPTH);
    localparam logic [3:0]     RCNT_LOAD   = 4'(RECOVER_CYCLES - 1);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    logic [AW-1:0]  r_rob_head;
    logic [AW-1:0]  r_rob_tail;
    logic [RCW-1:0] r_rob_cnt;
    logic [SW-1:0]  r_store_head;
    logic [SW-1:0]  r_store_ret;
    logic [SW-1:0]  r_store_tail;
    logic [SCW-1:0] r_sq_cnt;
    logic [IW-1:0]  r_iq_credit;
    logic [0:0]     r_state;
    logic [3:0]     r_rcnt;

    logic [1:0]     w_need;
    logic [1:0]     w_st_need;
    logic [RCW-1:0] w_rob_free;
    logic [SCW-1:0] w_sq_free;
    logic           w_rob_ok;
    logic           w_sq_ok;
    logic           w_iq_ok;
    logic           w_fire;
    logic [1:0]     w_disp_n;
    logic [1:0]     w_disp_st;
    logic [AW-1:0]  w_rob_head_nx;
    logic [SW-1:0]  w_store_ret_nx;
    logic [SW-1:0]  w_store_head_nx;
    logic [SW-1:0]  w_sq_ret_diff;

    // Dispatch only sees resources already freed by earlier cycles; this cycle's retires are not bypassed.
    assign w_need     = {1'b0, inst1_valid} + {1'b0, inst2_valid};
    assign w_st_need  = {1'b0, inst1_valid & inst1_is_store_op} + {1'b0, inst2_valid & inst2_is_store_op};
    assign w_rob_free = ROB_CAP - r_rob_cnt;
    assign w_sq_free  = SQ_CAP - r_sq_cnt;
    assign w_rob_ok   = w_rob_free >= RCW'(w_need);
    assign w_sq_ok    = w_sq_free >= SCW'(w_st_need);
    assign w_iq_ok    = r_iq_credit >= IW'(w_need);

    assign w_fire = resetn && ds_valid && (w_need != 2'd0) && (r_state == ST_RUN) && !flush
                    && w_rob_ok && w_sq_ok && w_iq_ok;

    assign w_disp_n  = w_fire ? w_need : 2'd0;
    assign w_disp_st = w_fire ? w_st_need : 2'd0;

    assign w_rob_head_nx   = r_rob_head + AW'(rob_commit_num);
    assign w_store_ret_nx  = r_store_ret + SW'(rob_commit_store_num);
    assign w_store_head_nx = r_store_head + SW'(sq_drain_num);
    assign w_sq_ret_diff   = w_store_ret_nx - w_store_head_nx;

    assign ds_to_is_valid  = w_fire;
    assign ds_to_rob_valid = w_fire;
    assign ds_allowin      = !ds_valid || w_fire;
    assign rob_head_o      = r_rob_head;
    assign rob_tail_o      = r_rob_tail;
    assign store_head      = r_store_head;
    assign store_tail      = r_store_tail;
    assign rob_full        = (r_rob_cnt == ROB_CAP);
    assign sq_full         = (r_sq_cnt == SQ_CAP);

    // On flush only retired stores survive, so the store tail and count collapse onto the retire pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rob_head   <= '0;
            r_rob_tail   <= '0;
            r_rob_cnt    <= '0;
            r_store_head <= '0;
            r_store_ret  <= '0;
            r_store_tail <= '0;
            r_sq_cnt     <= '0;
            r_iq_credit  <= IQ_CAP;
        end else begin
            r_rob_head   <= w_rob_head_nx;
            r_store_ret  <= w_store_ret_nx;
            r_store_head <= w_store_head_nx;
            if (flush) begin
                r_rob_tail   <= w_rob_head_nx;
                r_rob_cnt    <= '0;
                r_store_tail <= w_store_ret_nx;
                r_sq_cnt     <= {1'b0, w_sq_ret_diff};
                r_iq_credit  <= IQ_CAP;
            end else begin
                r_rob_tail   <= r_rob_tail + AW'(w_disp_n);
                r_rob_cnt    <= r_rob_cnt + RCW'(w_disp_n) - RCW'(rob_commit_num);
                r_store_tail <= r_store_tail + SW'(w_disp_st);
                r_sq_cnt     <= r_sq_cnt + SCW'(w_disp_st) - SCW'(sq_drain_num);
                r_iq_credit  <= r_iq_credit + IW'(iq_release_num) - IW'(w_disp_n);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
            r_rcnt  <= '0;
        end else if (flush) begin
            r_state <= ST_RECOVER;
            r_rcnt  <= RCNT_LOAD;
        end else if (r_state == ST_RECOVER) begin
            if (r_rcnt == 4'd0) begin
                r_state <= ST_RUN;
            end else begin
                r_rcnt <= r_rcnt - 4'd1;
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] r_stall_rob;
    logic [31:0] r_stall_sq;
    logic [31:0] r_stall_iq;
    logic [31:0] r_stall_rec;

    // Each stalled cycle is charged to the highest-priority blocking cause only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_rob <= '0;
            r_stall_sq  <= '0;
            r_stall_iq  <= '0;
            r_stall_rec <= '0;
        end else if (ds_valid && !w_fire) begin
            if ((r_state == ST_RECOVER) || flush) begin
                r_stall_rec <= r_stall_rec + 32'd1;
            end else if (!w_rob_ok) begin
                r_stall_rob <= r_stall_rob + 32'd1;
            end else if (!w_sq_ok) begin
                r_stall_sq <= r_stall_sq + 32'd1;
            end else if (!w_iq_ok) begin
                r_stall_iq <= r_stall_iq + 32'd1;
            end
        end
    end

    assign stall_rob_cnt = r_stall_rob;
    assign stall_sq_cnt  = r_stall_sq;
    assign stall_iq_cnt  = r_stall_iq;
    assign stall_rec_cnt = r_stall_rec;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn) begin
            assert (RCW'(rob_commit_num) <= r_rob_cnt);
            assert (!(sq_drain_num && (r_store_head == r_store_ret)));
            assert (r_iq_credit <= IQ_CAP);
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomized scoreboard bench for dispatch_ctrl: a queue-based reference model predicts each cycle's
// dispatch decision and pointer state, and an independent monitor compares the DUT against it.
module tb_dispatch_ctrl;

    localparam int ROB_DEPTH      = 16;
    localparam int SQ_DEPTH       = 16;
    localparam int IQ_DEPTH       = 8;
    localparam int RECOVER_CYCLES = 2;
    localparam int NUM_CYCLES     = 720;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ds_valid;
    logic       inst1_valid;
    logic       inst2_valid;
    logic       inst1_is_store_op;
    logic       inst2_is_store_op;
    logic [1:0] rob_commit_num;
    logic [1:0] rob_commit_store_num;
    logic       sq_drain_num;
    logic [1:0] iq_release_num;
    logic       flush;
    logic       ds_to_is_valid;
    logic       ds_to_rob_valid;
    logic       ds_allowin;
    logic [3:0] rob_head_o;
    logic [3:0] rob_tail_o;
    logic [3:0] store_head;
    logic [3:0] store_tail;
    logic       rob_full;
    logic       sq_full;

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .ROB_DEPTH      (ROB_DEPTH),
        .SQ_DEPTH       (SQ_DEPTH),
        .IQ_DEPTH       (IQ_DEPTH),
        .RECOVER_CYCLES (RECOVER_CYCLES)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .ds_valid             (ds_valid),
        .inst1_valid          (inst1_valid),
        .inst2_valid          (inst2_valid),
        .inst1_is_store_op    (inst1_is_store_op),
        .inst2_is_store_op    (inst2_is_store_op),
        .rob_commit_num       (rob_commit_num),
        .rob_commit_store_num (rob_commit_store_num),
        .sq_drain_num         (sq_drain_num),
        .iq_release_num       (iq_release_num),
        .flush                (flush),
        .ds_to_is_valid       (ds_to_is_valid),
        .ds_to_rob_valid      (ds_to_rob_valid),
        .ds_allowin           (ds_allowin),
        .rob_head_o           (rob_head_o),
        .rob_tail_o           (rob_tail_o),
        .store_head           (store_head),
        .store_tail           (store_tail),
        .rob_full             (rob_full),
        .sq_full              (sq_full)
    );

    typedef struct {
        bit fire;
        bit allowin;
        int robHead;
        int robTail;
        int storeHead;
        int storeTail;
        bit robFull;
        bit sqFull;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  failures = 0;
    bit  monitorOn = 0;

    // Reference model: the ROB is a queue of in-flight entries (1 = store), everything else plain counts.
    bit  robQ[$];
    int  robHead, robTail, storeHead, storeRet, storeTail;
    int  sqRet, iqOcc, recoverLeft;

    function automatic int storesInRob();
        int n = 0;
        foreach (robQ[i]) n += robQ[i];
        return n;
    endfunction

    task automatic modelReset();
        robQ.delete();
        robHead = 0; robTail = 0;
        storeHead = 0; storeRet = 0; storeTail = 0;
        sqRet = 0; iqOcc = 0; recoverLeft = 0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of random inputs, push the predicted response and advance the model past the edge.
    task automatic applyStimulus(input bit inReset, input int commitPct, input int releasePct,
                                 input int flushPct);
        expT e;
        int  need, stNeed, cmt, stCmt, rel, sqOcc, maxC, maxR;
        ds_valid          = ($urandom_range(0, 99) < 80);
        inst1_valid       = ($urandom_range(0, 99) < 85);
        inst2_valid       = ($urandom_range(0, 99) < 70);
        inst1_is_store_op = ($urandom_range(0, 3) == 0);
        inst2_is_store_op = ($urandom_range(0, 3) == 0);
        if (inReset) begin
            rob_commit_num = 0; rob_commit_store_num = 0; sq_drain_num = 0;
            iq_release_num = 0; flush = 0;
            e.fire = 0; e.allowin = !ds_valid;
            e.robHead = 0; e.robTail = 0; e.storeHead = 0; e.storeTail = 0;
            e.robFull = 0; e.sqFull = 0;
            expQ.push_back(e);
            modelReset();
            return;
        end
        maxC = (robQ.size() < 2) ? robQ.size() : 2;
        cmt = 0;
        if (sqRet < SQ_DEPTH - 2 && maxC > 0 && $urandom_range(0, 99) < commitPct)
            cmt = $urandom_range(1, maxC);
        stCmt = 0;
        for (int i = 0; i < cmt; i++) stCmt += robQ[i];
        maxR = (iqOcc < 2) ? iqOcc : 2;
        rel = ($urandom_range(0, 99) < releasePct) ? $urandom_range(0, maxR) : 0;
        rob_commit_num       = 2'(cmt);
        rob_commit_store_num = 2'(stCmt);
        sq_drain_num         = (sqRet > 0) && ($urandom_range(0, 3) != 0);
        iq_release_num       = 2'(rel);
        flush                = ($urandom_range(0, 99) < flushPct);

        need   = int'(inst1_valid) + int'(inst2_valid);
        stNeed = int'(inst1_valid && inst1_is_store_op) + int'(inst2_valid && inst2_is_store_op);
        sqOcc  = sqRet + storesInRob();
        e.fire = ds_valid && need != 0 && recoverLeft == 0 && !flush
                 && (ROB_DEPTH - robQ.size()) >= need
                 && (SQ_DEPTH - sqOcc) >= stNeed
                 && (IQ_DEPTH - iqOcc) >= need;
        e.allowin   = !ds_valid || e.fire;
        e.robHead   = robHead;
        e.robTail   = robTail;
        e.storeHead = storeHead;
        e.storeTail = storeTail;
        e.robFull   = (robQ.size() == ROB_DEPTH);
        e.sqFull    = (sqOcc == SQ_DEPTH);
        expQ.push_back(e);

        for (int i = 0; i < cmt; i++) void'(robQ.pop_front());
        robHead  = (robHead + cmt) % ROB_DEPTH;
        storeRet = (storeRet + stCmt) % SQ_DEPTH;
        sqRet   += stCmt;
        if (sq_drain_num) begin
            sqRet--;
            storeHead = (storeHead + 1) % SQ_DEPTH;
        end
        if (flush) begin
            robQ.delete();
            robTail     = robHead;
            storeTail   = storeRet;
            iqOcc       = 0;
            recoverLeft = RECOVER_CYCLES;
        end else begin
            if (recoverLeft > 0) recoverLeft--;
            iqOcc -= rel;
            if (e.fire) begin
                if (inst1_valid) robQ.push_back(inst1_is_store_op);
                if (inst2_valid) robQ.push_back(inst2_is_store_op);
                robTail   = (robTail + need) % ROB_DEPTH;
                storeTail = (storeTail + stNeed) % SQ_DEPTH;
                iqOcc    += need;
            end
        end
    endtask

    // Monitor: one prediction per cycle, compared mid-cycle while inputs and outputs are settled.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got 0 entries, expected 1", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ds_to_is_valid", int'(ds_to_is_valid), int'(e.fire));
                    checkOutput("ds_to_rob_valid", int'(ds_to_rob_valid), int'(e.fire));
                    checkOutput("ds_allowin", int'(ds_allowin), int'(e.allowin));
                    checkOutput("rob_head_o", int'(rob_head_o), e.robHead);
                    checkOutput("rob_tail_o", int'(rob_tail_o), e.robTail);
                    checkOutput("store_head", int'(store_head), e.storeHead);
                    checkOutput("store_tail", int'(store_tail), e.storeTail);
                    checkOutput("rob_full", int'(rob_full), int'(e.robFull));
                    checkOutput("sq_full", int'(sq_full), int'(e.sqFull));
                end
            end
        end
    end

    initial begin
        int commitPct, releasePct, flushPct;
        resetn = 1'b0;
        ds_valid = 0; inst1_valid = 0; inst2_valid = 0;
        inst1_is_store_op = 0; inst2_is_store_op = 0;
        rob_commit_num = 0; rob_commit_store_num = 0; sq_drain_num = 0;
        iq_release_num = 0; flush = 0;
        modelReset();
        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(posedge clk);
            #1;
            if (c == 3)   resetn = 1'b1;
            if (c == 520) resetn = 1'b0;
            if (c == 523) resetn = 1'b1;
            if (c < 200) begin
                commitPct = 60; releasePct = 70; flushPct = 3;
            end else if (c < 320) begin
                commitPct = 0;  releasePct = 95; flushPct = 0;
            end else if (c < 420) begin
                commitPct = 60; releasePct = 0;  flushPct = 0;
            end else if (c < 520) begin
                commitPct = 50; releasePct = 60; flushPct = 15;
            end else begin
                commitPct = 60; releasePct = 70; flushPct = 4;
            end
            monitorOn = 1;
            applyStimulus(!resetn, commitPct, releasePct, flushPct);
        end
        @(negedge clk);
        #1;
        monitorOn = 0;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Dispatch resource controller for the dual-issue out-of-order core. It sits between decode/rename and the issue queue/ROB, and owns the ROB tail, store-queue head/tail and issue-queue credit state consumed by instruction dispatch. Each cycle it decides whether the decoded pair may dispatch (`ds_to_is_valid`/`ds_to_rob_valid`), advances the pointers on dispatch, retire and drain, and restores them on a pipeline flush followed by a fixed recovery window.

## Interface
Parameters:
- `ROB_DEPTH`, default 16: ROB entries, power of two; `rob_tail_o`/`rob_head_o` are `$clog2(ROB_DEPTH)` bits wide (4 at default).
- `SQ_DEPTH`, default 16: store-queue entries, power of two; store pointers are `$clog2(SQ_DEPTH)` bits wide.
- `IQ_DEPTH`, default 8: issue-queue entries, tracked as credits.
- `RECOVER_CYCLES`, default 2: dispatch-blocked cycles after a flush, range 1..15.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ds_valid` in 1: decode holds a renamed pair this cycle.
- `inst1_valid`, `inst2_valid` in 1 each: slot occupancy.
- `inst1_is_store_op`, `inst2_is_store_op` in 1 each: slot is a store.
- `rob_commit_num` in 2: ROB entries retired this cycle, 0..2.
- `rob_commit_store_num` in 2: stores among the retired entries, ≤ `rob_commit_num`.
- `sq_drain_num` in 1: one retired store written to the cache this cycle.
- `iq_release_num` in 2: issue-queue entries freed this cycle, 0..2.
- `flush` in 1: exception or mispredict squash.
- `ds_to_is_valid` out 1: pair dispatches to issue.
- `ds_to_rob_valid` out 1: pair dispatches to the ROB; always equals `ds_to_is_valid`.
- `ds_allowin` out 1: decode may advance; `!ds_valid || fire`.
- `rob_head_o`, `rob_tail_o` out: ROB pointers.
- `store_head`, `store_tail` out: store-queue pointers.
- `rob_full`, `sq_full` out 1 each: occupancy equals depth.

## Operation
- `need` = `inst1_valid` + `inst2_valid`.
- `st_need` = `inst1_is_store_op && inst1_valid` + `inst2_is_store_op && inst2_valid`.
- `fire` = `ds_valid && need != 0 && state == RUN && !flush && (ROB_DEPTH - rob_cnt) >= need && (SQ_DEPTH - sq_cnt) >= st_need && iq_credit >= need`.
- `fire` is combinational from registered state and current inputs.
- State registers:
  - `rob_head`, `rob_tail`, `rob_cnt`: count is `$clog2(ROB_DEPTH)+1` bits.
  - `store_head`, `store_ret`, `store_tail`, `sq_cnt`: `store_ret` marks retired, not-yet-drained stores.
  - `iq_credit`, `state`, `rcnt`.
- Per-cycle updates, all additive and applied in the same cycle (a simultaneous dispatch, retire and release net out):
  - `rob_head += rob_commit_num`; `rob_cnt += need·fire − rob_commit_num`.
  - `rob_tail += need·fire`.
  - `store_ret += rob_commit_store_num`; `store_head += sq_drain_num`.
  - `store_tail += st_need·fire`; `sq_cnt += st_need·fire − sq_drain_num`.
  - `iq_credit += iq_release_num − need·fire`.
- Pointers wrap modulo depth.
- Resources freed in cycle N are usable for `fire` from cycle N+1; there is no same-cycle bypass.
- Flush, which overrides `fire`:
  - `rob_tail <= rob_head + rob_commit_num`; `rob_cnt <= 0`.
  - `store_tail <= store_ret + rob_commit_store_num`.
  - `sq_cnt <= (store_ret + rob_commit_store_num) − (store_head + sq_drain_num)`. Retired stores survive the flush; drain continues normally.
  - `iq_credit <= IQ_DEPTH`.
  - `state <= RECOVER`; `rcnt <= RECOVER_CYCLES - 1`.
- FSM:
  - RUN → RECOVER on `flush`.
  - RECOVER: `fire` = 0; `rcnt` decrements each cycle; RECOVER → RUN when `rcnt == 0`.
  - A `flush` during RECOVER reloads `rcnt`.
- Illegal-input assertions (simulation only):
  - `rob_commit_num > rob_cnt`.
  - `sq_drain_num` while `store_head == store_ret`.
  - `iq_credit` exceeding `IQ_DEPTH`.

## Timing
- Reset values:
  - All pointers and counts 0; `iq_credit = IQ_DEPTH`; state RUN; `rcnt` 0.
  - `ds_to_is_valid`, `ds_to_rob_valid`, `rob_full`, `sq_full` are 0.
  - `ds_allowin` = `!ds_valid`.
- Dispatch decision latency is 0 cycles (combinational). Pointer outputs reflect a dispatch one cycle after `fire`.
- `rob_full` and `sq_full` are decoded from registered counts.
- Async reset mid-operation returns all state to reset values immediately, independent of `clk`.
- The first dispatch after `flush` in cycle N is possible in cycle N+1+`RECOVER_CYCLES`.

## Configuration
- `DISPATCH_PERF_CNT_EN` defined:
  - Adds 32-bit outputs `stall_rob_cnt`, `stall_sq_cnt`, `stall_iq_cnt`, `stall_rec_cnt`.
  - Each increments once per cycle with `ds_valid && !fire`, attributed to exactly one cause in priority RECOVER/flush > ROB > SQ > IQ.
  - Counters wrap, reset to 0, and hold their values across `flush`.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- After reset, dispatch 8 non-store pairs with no commits → `rob_tail_o` steps 2,4,…,16→0; `rob_full`=1 after the 8th pair; the 9th pair gets `fire`=0.
- With `rob_cnt=15`: a pair is blocked; a single inst dispatches and `rob_tail_o` +1; commit 2 and dispatch in the same cycle → `rob_cnt` nets correctly, and the freed entries are usable only on the next cycle.
- Store pair with `store_tail=15`, `sq_cnt=14` → `fire`, `store_tail`=1 (wrap), `sq_full`=1; the next store is blocked until `sq_drain_num`.
- `iq_credit=1` with a 2-inst pair → stall; `iq_release_num=1` → dispatch fires next cycle; credit returns to 0.
- Pointers before the flush cycle: `store_ret=3`, `store_head=1`, `rob_head=5`. In the flush cycle `rob_commit_num=1` and `rob_commit_store_num=0` → `rob_tail`=6, `store_tail`=3, `sq_cnt`=2, credit=`IQ_DEPTH`. `fire` stays 0 for 2 cycles; a second flush in RECOVER extends the window.
- With `DISPATCH_PERF_CNT_EN`: a simultaneous ROB-full and IQ-empty stall for 5 cycles → `stall_rob_cnt`=5, `stall_iq_cnt`=0.
